// File: rtl/cpm_bank_sched.sv
// cpm_bank_sched -- multi-bank burst scheduler.
//
// Each of BANK_N = 2^IDX_AW banks runs its own IDLE/BUSY machine with a beat
// counter, an owner register and a round-robin pointer. Requesters target one
// bank each (REQ_IDX) and ask for a burst of REQ_LEN+1 beats. A bank accepts
// a new owner when idle or on the last beat of its current burst, so bursts
// chain across owners with no bubble.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   REQ_VLD   per-requester request valid, held until accepted
//   REQ_IDX   per-requester target bank (REQ_DW x IDX_AW, packed)
//   REQ_LEN   per-requester burst length minus one (REQ_DW x LEN_W, packed)
//   REQ_RDY   combinational accept pulse, high in the acceptance cycle
//   GNT_ARB   registered: requester owns its bank this cycle (one beat)
//   GNT_IDX   registered: owner of each bank, 0 when idle (BANK_N x REQ_AW)
//   BANK_BSY  registered: bank is in BUSY
//   REQ_DONE  registered: last beat of the owner's burst
module cpm_bank_sched #(
  parameter  int REQ_DW = 4,
  parameter  int IDX_AW = 2,
  parameter  int LEN_W  = 4,
  localparam int REQ_AW = $clog2(REQ_DW),
  localparam int BANK_N = 1 << IDX_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_DW-1:0]          REQ_VLD,
  input  logic [REQ_DW*IDX_AW-1:0]   REQ_IDX,
  input  logic [REQ_DW*LEN_W-1:0]    REQ_LEN,
  output logic [REQ_DW-1:0]          REQ_RDY,
  output logic [REQ_DW-1:0]          GNT_ARB,
  output logic [BANK_N*REQ_AW-1:0]   GNT_IDX,
  output logic [BANK_N-1:0]          BANK_BSY,
  output logic [REQ_DW-1:0]          REQ_DONE
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                r_state [BANK_N];
  logic [LEN_W-1:0]      r_cnt   [BANK_N];
  logic [REQ_AW-1:0]     r_own   [BANK_N];
  logic [REQ_AW-1:0]     r_ptr   [BANK_N];
  logic [REQ_DW-1:0]     r_gnt_arb;
  logic [BANK_N*REQ_AW-1:0] r_gnt_idx;
  logic [BANK_N-1:0]     r_bank_bsy;
  logic [REQ_DW-1:0]     r_req_done;

  state_t                w_nxt_state [BANK_N];
  logic [LEN_W-1:0]      w_nxt_cnt   [BANK_N];
  logic [REQ_AW-1:0]     w_nxt_own   [BANK_N];
  logic [REQ_AW-1:0]     w_nxt_ptr   [BANK_N];
  logic [REQ_DW-1:0]     w_cand      [BANK_N];
  logic [REQ_AW:0]       w_pick      [BANK_N];
  logic [BANK_N-1:0]     w_acc;
  logic [REQ_DW-1:0]     w_blocked;
  logic [REQ_DW-1:0]     w_gnt_n;
  logic [REQ_DW-1:0]     w_done_n;
  logic [BANK_N*REQ_AW-1:0] w_gidx_n;
  logic [BANK_N-1:0]     w_bsy_n;

  // Round-robin pick: first set bit searching upward from ptr+1 with wrap.
  // Returns {found, index}.
  function automatic logic [REQ_AW:0] rr_pick(input logic [REQ_DW-1:0] cand,
                                              input logic [REQ_AW-1:0] ptr);
    logic [REQ_AW:0] res;
    int k;
    res = '0;
    for (int i = 1; i <= REQ_DW; i++) begin
      k = (int'(ptr) + i) % REQ_DW;
      if (!res[REQ_AW] && cand[k]) res = {1'b1, REQ_AW'(k)};
    end
    return res;
  endfunction

  always_comb begin
    // A requester still owning beats after this cycle may not start a new
    // burst; on its last beat it is free to be re-accepted back-to-back.
    w_blocked = '0;
    for (int b = 0; b < BANK_N; b++)
      for (int r = 0; r < REQ_DW; r++)
        if (r_state[b] == S_BUSY && r_cnt[b] != '0 && r_own[b] == REQ_AW'(r))
          w_blocked[r] = 1'b1;

    REQ_RDY  = '0;
    w_gnt_n  = '0;
    w_done_n = '0;
    w_gidx_n = '0;
    w_bsy_n  = '0;
    w_acc    = '0;
    for (int b = 0; b < BANK_N; b++) begin
      for (int r = 0; r < REQ_DW; r++)
        w_cand[b][r] = REQ_VLD[r] && !w_blocked[r] &&
                       (REQ_IDX[r*IDX_AW +: IDX_AW] == IDX_AW'(b));
      w_pick[b] = rr_pick(w_cand[b], r_ptr[b]);
      w_acc[b]  = w_pick[b][REQ_AW] && (r_state[b] == S_IDLE || r_cnt[b] == '0);

      w_nxt_state[b] = r_state[b];
      w_nxt_cnt[b]   = r_cnt[b];
      w_nxt_own[b]   = r_own[b];
      w_nxt_ptr[b]   = r_ptr[b];
      if (w_acc[b]) begin
        w_nxt_state[b] = S_BUSY;
        w_nxt_cnt[b]   = REQ_LEN[int'(w_pick[b][REQ_AW-1:0])*LEN_W +: LEN_W];
        w_nxt_own[b]   = w_pick[b][REQ_AW-1:0];
        w_nxt_ptr[b]   = w_pick[b][REQ_AW-1:0];
        if (!rst) REQ_RDY[w_pick[b][REQ_AW-1:0]] = 1'b1;
      end else if (r_state[b] == S_BUSY) begin
        if (r_cnt[b] == '0) begin
          w_nxt_state[b] = S_IDLE;
          w_nxt_own[b]   = '0;
        end else begin
          w_nxt_cnt[b] = r_cnt[b] - LEN_W'(1);
        end
      end

      // Outputs are decoded from next state so they register in step with it.
      if (w_nxt_state[b] == S_BUSY) begin
        w_gnt_n[w_nxt_own[b]] = 1'b1;
        if (w_nxt_cnt[b] == '0) w_done_n[w_nxt_own[b]] = 1'b1;
        w_gidx_n[b*REQ_AW +: REQ_AW] = w_nxt_own[b];
        w_bsy_n[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANK_N; b++) begin
        r_state[b] <= S_IDLE;
        r_cnt[b]   <= '0;
        r_own[b]   <= '0;
        r_ptr[b]   <= REQ_AW'(REQ_DW - 1);
      end
      r_gnt_arb  <= '0;
      r_gnt_idx  <= '0;
      r_bank_bsy <= '0;
      r_req_done <= '0;
    end else begin
      for (int b = 0; b < BANK_N; b++) begin
        r_state[b] <= w_nxt_state[b];
        r_cnt[b]   <= w_nxt_cnt[b];
        r_own[b]   <= w_nxt_own[b];
        r_ptr[b]   <= w_nxt_ptr[b];
      end
      r_gnt_arb  <= w_gnt_n;
      r_gnt_idx  <= w_gidx_n;
      r_bank_bsy <= w_bsy_n;
      r_req_done <= w_done_n;
    end
  end

  assign GNT_ARB  = r_gnt_arb;
  assign GNT_IDX  = r_gnt_idx;
  assign BANK_BSY = r_bank_bsy;
  assign REQ_DONE = r_req_done;

endmodule

// File: tb/tb_cpm_bank_sched.sv
// Directed testbench for cpm_bank_sched (default parameters: 4 requesters,
// 4 banks, 4-bit length). Inputs are driven 1 time unit after the rising
// edge; outputs are sampled on the falling edge of the same cycle.
module tb_cpm_bank_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  REQ_VLD;
  logic [7:0]  REQ_IDX;
  logic [15:0] REQ_LEN;
  logic [3:0]  REQ_RDY;
  logic [3:0]  GNT_ARB;
  logic [7:0]  GNT_IDX;
  logic [3:0]  BANK_BSY;
  logic [3:0]  REQ_DONE;

  int n_chk;
  int n_fail;

  cpm_bank_sched #(.REQ_DW(4), .IDX_AW(2), .LEN_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .REQ_VLD  (REQ_VLD),
    .REQ_IDX  (REQ_IDX),
    .REQ_LEN  (REQ_LEN),
    .REQ_RDY  (REQ_RDY),
    .GNT_ARB  (GNT_ARB),
    .GNT_IDX  (GNT_IDX),
    .BANK_BSY (BANK_BSY),
    .REQ_DONE (REQ_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int r, input logic v, input logic [1:0] b, input logic [3:0] l);
    REQ_VLD[r]        = v;
    REQ_IDX[r*2 +: 2] = b;
    REQ_LEN[r*4 +: 4] = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 2'd0, 4'd0);
    set_req(1, 1'b1, 2'd1, 4'd0);
    samp();
    n_chk++; if (REQ_RDY !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got %b want 0000", REQ_RDY); end
    step(); samp();
    n_chk++; if (GNT_ARB !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", GNT_ARB); end
    n_chk++; if (GNT_IDX !== 8'h00) begin n_fail++; $display("FAIL reset_gidx got %h want 00", GNT_IDX); end
    n_chk++; if (BANK_BSY !== 4'b0000) begin n_fail++; $display("FAIL reset_bsy got %b want 0000", BANK_BSY); end
    n_chk++; if (REQ_DONE !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", REQ_DONE); end
    step();
    set_req(0, 1'b0, 2'd0, 4'd0);
    set_req(1, 1'b0, 2'd0, 4'd0);
    rst = 1'b0;
    samp();
  endtask

  task automatic test_single();
    logic [3:0] eg, ed, eb;
    step();
    set_req(0, 1'b1, 2'd1, 4'd2);
    samp();
    n_chk++; if (REQ_RDY !== 4'b0001) begin n_fail++; $display("FAIL single_rdy0 got %b want 0001", REQ_RDY); end
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) set_req(0, 1'b0, 2'd0, 4'd0);
      samp();
      eg = (c <= 3) ? 4'b0001 : 4'b0000;
      ed = (c == 3) ? 4'b0001 : 4'b0000;
      eb = (c <= 3) ? 4'b0010 : 4'b0000;
      n_chk++; if (GNT_ARB !== eg) begin n_fail++; $display("FAIL single_gnt c%0d got %b want %b", c, GNT_ARB, eg); end
      n_chk++; if (REQ_DONE !== ed) begin n_fail++; $display("FAIL single_done c%0d got %b want %b", c, REQ_DONE, ed); end
      n_chk++; if (BANK_BSY !== eb) begin n_fail++; $display("FAIL single_bsy c%0d got %b want %b", c, BANK_BSY, eb); end
      n_chk++; if (REQ_RDY !== 4'b0000) begin n_fail++; $display("FAIL single_rdy c%0d got %b want 0000", c, REQ_RDY); end
    end
  endtask

  task automatic test_contention();
    logic [1:0] order [6];
    logic [3:0] er, eg;
    order = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        set_req(0, 1'b1, 2'd0, 4'd0);
        set_req(2, 1'b1, 2'd0, 4'd0);
        set_req(3, 1'b1, 2'd0, 4'd0);
      end
      samp();
      er = 4'b0001 << order[c];
      n_chk++; if (REQ_RDY !== er) begin n_fail++; $display("FAIL cont_rdy c%0d got %b want %b", c, REQ_RDY, er); end
      if (c > 0) begin
        eg = 4'b0001 << order[c-1];
        n_chk++; if (GNT_ARB !== eg) begin n_fail++; $display("FAIL cont_gnt c%0d got %b want %b", c, GNT_ARB, eg); end
        n_chk++; if (REQ_DONE !== eg) begin n_fail++; $display("FAIL cont_done c%0d got %b want %b", c, REQ_DONE, eg); end
        n_chk++; if (GNT_IDX[1:0] !== order[c-1]) begin n_fail++; $display("FAIL cont_gidx c%0d got %0d want %0d", c, GNT_IDX[1:0], order[c-1]); end
      end
    end
    step();
    set_req(0, 1'b0, 2'd0, 4'd0);
    set_req(2, 1'b0, 2'd0, 4'd0);
    set_req(3, 1'b0, 2'd0, 4'd0);
    samp();
    n_chk++; if (GNT_ARB !== 4'b1000) begin n_fail++; $display("FAIL cont_last_gnt got %b want 1000", GNT_ARB); end
    n_chk++; if (REQ_RDY !== 4'b0000) begin n_fail++; $display("FAIL cont_last_rdy got %b want 0000", REQ_RDY); end
    step(); samp();
    n_chk++; if (BANK_BSY !== 4'b0000) begin n_fail++; $display("FAIL cont_idle got %b want 0000", BANK_BSY); end
  endtask

  task automatic test_parallel();
    step();
    set_req(0, 1'b1, 2'd0, 4'd1);
    set_req(1, 1'b1, 2'd3, 4'd1);
    samp();
    n_chk++; if (REQ_RDY !== 4'b0011) begin n_fail++; $display("FAIL par_rdy got %b want 0011", REQ_RDY); end
    step();
    set_req(0, 1'b0, 2'd0, 4'd0);
    set_req(1, 1'b0, 2'd0, 4'd0);
    samp();
    n_chk++; if (GNT_ARB !== 4'b0011) begin n_fail++; $display("FAIL par_gnt got %b want 0011", GNT_ARB); end
    n_chk++; if (GNT_IDX !== 8'h40) begin n_fail++; $display("FAIL par_gidx got %h want 40", GNT_IDX); end
    n_chk++; if (BANK_BSY !== 4'b1001) begin n_fail++; $display("FAIL par_bsy got %b want 1001", BANK_BSY); end
    step(); samp();
    n_chk++; if (REQ_DONE !== 4'b0011) begin n_fail++; $display("FAIL par_done got %b want 0011", REQ_DONE); end
    step(); samp();
    n_chk++; if (BANK_BSY !== 4'b0000) begin n_fail++; $display("FAIL par_idle got %b want 0000", BANK_BSY); end
    n_chk++; if (GNT_IDX !== 8'h00) begin n_fail++; $display("FAIL par_gidx_idle got %h want 00", GNT_IDX); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] er, eg, ed;
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) set_req(1, 1'b1, 2'd2, 4'd1);
      if (c == 3) set_req(1, 1'b0, 2'd0, 4'd0);
      samp();
      er = (c == 0 || c == 2) ? 4'b0010 : 4'b0000;
      eg = (c >= 1 && c <= 4) ? 4'b0010 : 4'b0000;
      ed = (c == 2 || c == 4) ? 4'b0010 : 4'b0000;
      n_chk++; if (REQ_RDY !== er) begin n_fail++; $display("FAIL b2b_rdy c%0d got %b want %b", c, REQ_RDY, er); end
      n_chk++; if (GNT_ARB !== eg) begin n_fail++; $display("FAIL b2b_gnt c%0d got %b want %b", c, GNT_ARB, eg); end
      n_chk++; if (REQ_DONE !== ed) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %b", c, REQ_DONE, ed); end
    end
  endtask

  task automatic test_reset_mid();
    step();
    set_req(0, 1'b1, 2'd0, 4'd7);
    samp();
    n_chk++; if (REQ_RDY !== 4'b0001) begin n_fail++; $display("FAIL rmid_rdy0 got %b want 0001", REQ_RDY); end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) begin
        set_req(0, 1'b0, 2'd0, 4'd0);
        set_req(3, 1'b1, 2'd0, 4'd0);
      end
      if (c == 3) rst = 1'b1;
      samp();
      if (c < 3) begin
        n_chk++; if (GNT_ARB !== 4'b0001) begin n_fail++; $display("FAIL rmid_gnt c%0d got %b want 0001", c, GNT_ARB); end
        n_chk++; if (REQ_RDY !== 4'b0000) begin n_fail++; $display("FAIL rmid_rdy c%0d got %b want 0000", c, REQ_RDY); end
        n_chk++; if (REQ_DONE !== 4'b0000) begin n_fail++; $display("FAIL rmid_done c%0d got %b want 0000", c, REQ_DONE); end
      end
    end
    n_chk++; if ({REQ_RDY, GNT_ARB, BANK_BSY, REQ_DONE} !== 16'h0000) begin n_fail++; $display("FAIL rmid_abort got %h want 0000", {REQ_RDY, GNT_ARB, BANK_BSY, REQ_DONE}); end
    n_chk++; if (GNT_IDX !== 8'h00) begin n_fail++; $display("FAIL rmid_abort_gidx got %h want 00", GNT_IDX); end
    step(); samp();
    n_chk++; if ({REQ_RDY, GNT_ARB, REQ_DONE} !== 12'h000) begin n_fail++; $display("FAIL rmid_hold got %h want 000", {REQ_RDY, GNT_ARB, REQ_DONE}); end
    step();
    rst = 1'b0;
    samp();
    n_chk++; if (REQ_RDY !== 4'b1000) begin n_fail++; $display("FAIL rmid_rel_rdy got %b want 1000", REQ_RDY); end
    n_chk++; if (GNT_ARB !== 4'b0000) begin n_fail++; $display("FAIL rmid_rel_gnt got %b want 0000", GNT_ARB); end
    step();
    set_req(3, 1'b0, 2'd0, 4'd0);
    samp();
    n_chk++; if (GNT_ARB !== 4'b1000) begin n_fail++; $display("FAIL rmid_r3_gnt got %b want 1000", GNT_ARB); end
    n_chk++; if (REQ_DONE !== 4'b1000) begin n_fail++; $display("FAIL rmid_r3_done got %b want 1000", REQ_DONE); end
    n_chk++; if (GNT_IDX[1:0] !== 2'd3) begin n_fail++; $display("FAIL rmid_r3_gidx got %0d want 3", GNT_IDX[1:0]); end
    step(); samp();
    n_chk++; if (BANK_BSY !== 4'b0000) begin n_fail++; $display("FAIL rmid_idle got %b want 0000", BANK_BSY); end
  endtask

  task automatic test_withdraw();
    logic [3:0] eg, ed;
    step();
    set_req(0, 1'b1, 2'd0, 4'd3);
    samp();
    n_chk++; if (REQ_RDY !== 4'b0001) begin n_fail++; $display("FAIL wd_rdy0 got %b want 0001", REQ_RDY); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        set_req(0, 1'b0, 2'd0, 4'd0);
        set_req(2, 1'b1, 2'd0, 4'd0);
      end
      if (c == 3) set_req(2, 1'b0, 2'd0, 4'd0);
      samp();
      eg = (c <= 4) ? 4'b0001 : 4'b0000;
      ed = (c == 4) ? 4'b0001 : 4'b0000;
      n_chk++; if (REQ_RDY !== 4'b0000) begin n_fail++; $display("FAIL wd_rdy c%0d got %b want 0000", c, REQ_RDY); end
      n_chk++; if (GNT_ARB !== eg) begin n_fail++; $display("FAIL wd_gnt c%0d got %b want %b", c, GNT_ARB, eg); end
      n_chk++; if (REQ_DONE !== ed) begin n_fail++; $display("FAIL wd_done c%0d got %b want %b", c, REQ_DONE, ed); end
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    REQ_VLD = '0;
    REQ_IDX = '0;
    REQ_LEN = '0;
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_back_to_back();
    test_reset_mid();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpm_bank_sched.md
CPM_BANK_SCHED -- requirements
Module: cpm_bank_sched

Interface
REQ-001 SHALL have parameter REQ_DW, default 4, meaning number of requesters.
REQ-002 SHALL have parameter IDX_AW, default 2, meaning bank index width; number of banks is BANK_N = 2^IDX_AW.
REQ-003 SHALL have parameter LEN_W, default 4, meaning burst length field width; encoding is beats-1.
REQ-004 SHALL have derived parameter REQ_AW = $clog2(REQ_DW).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port REQ_VLD, input, REQ_DW, per-requester request valid; held until accepted.
REQ-008 SHALL have port REQ_IDX, input, REQ_DW x IDX_AW, target bank per requester.
REQ-009 SHALL have port REQ_LEN, input, REQ_DW x LEN_W, burst beats-1 per requester.
REQ-010 SHALL have port REQ_RDY, input-accept pulse, output, REQ_DW, combinational; high in the cycle the request is accepted.
REQ-011 SHALL have port GNT_ARB, output, REQ_DW, registered; requester owns its bank this cycle (one beat).
REQ-012 SHALL have port GNT_IDX, output, BANK_N x REQ_AW, registered; current owner of each bank, 0 when idle.
REQ-013 SHALL have port BANK_BSY, output, BANK_N, registered; bank in BUSY.
REQ-014 SHALL have port REQ_DONE, output, REQ_DW, registered; high on the last beat of a burst.

Function
REQ-015 Each bank SHALL run an independent FSM with states IDLE and BUSY, plus a LEN_W-bit beat counter, a REQ_AW-bit owner register and a REQ_AW-bit round-robin pointer.
REQ-016 Requester r SHALL be a candidate for bank b when REQ_VLD[r]=1, REQ_IDX[r]=b, and r is not owner of a bank with beats remaining beyond the current cycle.
REQ-017 Bank b SHALL accept when in IDLE, or in BUSY on its last beat (counter=0), and at least one candidate exists.
REQ-018 Winner selection SHALL be round-robin: the first candidate found searching upward, with wrap-around, from pointer+1.
REQ-019 On accept in cycle N: REQ_RDY[winner]=1 in cycle N; pointer<=winner, owner<=winner, counter<=REQ_LEN[winner], state<=BUSY at edge N+1.
REQ-020 Latency: GNT_ARB[winner] SHALL first assert in cycle N+1 and stay high for exactly REQ_LEN+1 consecutive cycles.
REQ-021 In BUSY the counter SHALL decrement each cycle; REQ_DONE[owner]=1 in the cycle the counter equals 0.
REQ-022 Last beat with no candidate: the bank SHALL return to IDLE at the next edge; GNT_IDX[b] becomes 0 and BANK_BSY[b] becomes 0.
REQ-023 Last beat with a candidate: the bank SHALL re-accept with zero bubble, so GNT_ARB is continuous across owners.
REQ-024 A requester's own next request SHALL be eligible on its last beat, giving back-to-back bursts without a gap.
REQ-025 REQ_RDY SHALL be one-hot per bank; across banks at most REQ_DW bits are set, and a requester is never accepted by two banks in one cycle.
REQ-026 REQ_VLD dropped before acceptance SHALL be treated as a withdrawn request with no side effect.
REQ-027 REQ_IDX and REQ_LEN SHALL be sampled only in the acceptance cycle; later changes do not affect an active burst.
REQ-028 REQ_LEN=0 SHALL produce a single-beat grant with GNT_ARB and REQ_DONE both high in the same cycle.

Reset
REQ-029 While rst=1: all banks IDLE; counters and owners 0; pointers REQ_DW-1 (requester 0 wins first); GNT_ARB, GNT_IDX, BANK_BSY, REQ_DONE all 0.
REQ-030 REQ_RDY SHALL be forced to 0 while rst=1.
REQ-031 Reset asserted mid-burst SHALL abort all bursts immediately with no REQ_DONE; after release, arbitration restarts from the reset pointers.

Verification
REQ-032 Single request r0: bank1, LEN=2, 1 cycle -> REQ_RDY[0] in cycle 0; GNT_ARB[0] in cycles 1-3; REQ_DONE[0] in cycle 3; BANK_BSY[1]=0 in cycle 4.
REQ-033 Contention r0, r2, r3 all request bank0, LEN=0, held -> grant order 0, 2, 3, 0, ... with GNT_ARB continuous and no idle cycle.
REQ-034 Parallel banks: r0 to bank0 and r1 to bank3 in the same cycle -> both REQ_RDY in the same cycle; both GNT_ARB set from the next cycle; GNT_IDX[0]=0 and GNT_IDX[3]=1.
REQ-035 Back-to-back: r1 issues two bursts of LEN=1 to bank2 -> GNT_ARB[1] high for 4 consecutive cycles; REQ_DONE[1] in cycles 2 and 4.
REQ-036 Reset during a LEN=7 burst at its third beat -> all outputs 0 within the same cycle; no REQ_DONE; after release, the pending r3 to bank0 request is granted 1 cycle later.
REQ-037 Withdrawal: r2 asserts REQ_VLD while bank0 is busy, then drops it before the owner's last beat -> r2 gets no REQ_RDY and no GNT_ARB.
